ultrasonic_echo_model: RTL

//  Synthesizable HC-SR04-style sensor responder: the far end of the trig/Echo interface driven by

---
 rtl/ultrasonic_echo_model_if.sv | 26 ++
 rtl/ultrasonic_echo_model.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ultrasonic_echo_model_if.sv
`default_nettype none
// ============================================================================
// Module      : ultrasonic_echo_model_if
// Description : trig/Echo link between a range measurement block (master)
//               and the emulated ultrasonic sensor (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ultrasonic_echo_model_if;
  logic       trig;
  logic [8:0] distance_cm;
  logic       no_object;
  logic       Echo;
  logic       busy;
  logic       trig_err;

  modport master (
    output trig, distance_cm, no_object,
    input  Echo, busy, trig_err
  );

  modport slave (
    input  trig, distance_cm, no_object,
    output Echo, busy, trig_err
  );
endinterface
`default_nettype wire

// File: rtl/ultrasonic_echo_model.sv
`default_nettype none
// ============================================================================
// Module      : ultrasonic_echo_model
// Description : HC-SR04 style sensor responder. Qualifies a trigger pulse,
//               waits out the emulated burst, then returns an Echo pulse
//               whose width encodes the programmed distance.
// Revision    : 1.0 - initial release
// ============================================================================
module ultrasonic_echo_model #(
  parameter int unsigned CYC_PER_US  = 50,
  parameter int unsigned TRIG_MIN_US = 10,
  parameter int unsigned BURST_US    = 200,
  parameter int unsigned US_PER_CM   = 58,
  parameter int unsigned MIN_CM      = 2,
  parameter int unsigned MAX_CM      = 400,
  parameter int unsigned TIMEOUT_US  = 38000,
  parameter int unsigned HOLDOFF_US  = 10000
) (
  input  logic                   sys_clk50m,
  input  logic                   sys_rst,
  ultrasonic_echo_model_if.slave bus
);

  localparam logic [21:0] TRIG_CYC    = 22'(TRIG_MIN_US * CYC_PER_US);
  localparam logic [21:0] BURST_CYC   = 22'(BURST_US * CYC_PER_US);
  localparam logic [21:0] HOLD_CYC    = 22'(HOLDOFF_US * CYC_PER_US);
  localparam logic [21:0] TIMEOUT_CYC = 22'(TIMEOUT_US * CYC_PER_US);
  localparam logic [21:0] CM_CYC      = 22'(US_PER_CM * CYC_PER_US);
  localparam logic [21:0] MIN_W       = 22'(MIN_CM * US_PER_CM * CYC_PER_US);
  localparam logic [8:0]  MIN_D       = 9'(MIN_CM);
  localparam logic [8:0]  MAX_D       = 9'(MAX_CM);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIG_HI = 3'd1,
    S_BURST   = 3'd2,
    S_ECHO    = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t      state_q;
  logic        trig_meta_q;
  logic        trig_s_q;
  logic        trig_prev_q;
  logic [21:0] cnt_q;
  logic [21:0] width_q;
  logic [21:0] echo_w_q;
  logic [21:0] echo_w_d;
  logic        echo_q;
  logic        busy_q;
  logic        trig_err_q;
  logic        trig_rise;

  assign trig_rise = trig_s_q & ~trig_prev_q;

  // Echo width for the live distance inputs; only captured at trigger acceptance
  always_comb begin
    echo_w_d = 22'(bus.distance_cm) * CM_CYC;
    if (bus.no_object || (bus.distance_cm > MAX_D)) begin
      echo_w_d = TIMEOUT_CYC;
    end else if (bus.distance_cm < MIN_D) begin
      echo_w_d = MIN_W;
    end
  end

  // Two-flop synchronizer plus edge history; reset to 1 so a trig level that
  // is already high never looks like a rising edge until it has been seen low
  always_ff @(posedge sys_clk50m) begin
    if (sys_rst) begin
      trig_meta_q <= 1'b1;
      trig_s_q    <= 1'b1;
      trig_prev_q <= 1'b1;
    end else begin
      trig_meta_q <= bus.trig;
      trig_s_q    <= trig_meta_q;
      trig_prev_q <= trig_s_q;
    end
  end

  // Trigger qualification, burst delay, echo pulse and holdoff sequencing
  always_ff @(posedge sys_clk50m) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      width_q    <= '0;
      echo_w_q   <= '0;
      echo_q     <= 1'b0;
      busy_q     <= 1'b0;
      trig_err_q <= 1'b0;
    end else begin
      // A new edge while a measurement is in flight is flagged but ignored
      trig_err_q <= trig_rise & busy_q;
      case (state_q)
        S_IDLE: begin
          if (trig_rise) begin
            state_q <= S_TRIG_HI;
            width_q <= 22'd1;
          end
        end
        S_TRIG_HI: begin
          if (trig_s_q) begin
            if (width_q < TRIG_CYC) begin
              width_q <= width_q + 22'd1;
            end
          end else if (width_q >= TRIG_CYC) begin
            echo_w_q <= echo_w_d;
            cnt_q    <= BURST_CYC - 22'd1;
            busy_q   <= 1'b1;
            state_q  <= S_BURST;
          end else begin
            trig_err_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        S_BURST: begin
          if (cnt_q == 22'd0) begin
            echo_q  <= 1'b1;
            cnt_q   <= echo_w_q - 22'd1;
            state_q <= S_ECHO;
          end else begin
            cnt_q <= cnt_q - 22'd1;
          end
        end
        S_ECHO: begin
          if (cnt_q == 22'd0) begin
            echo_q  <= 1'b0;
            cnt_q   <= HOLD_CYC - 22'd1;
            state_q <= S_HOLDOFF;
          end else begin
            cnt_q <= cnt_q - 22'd1;
          end
        end
        S_HOLDOFF: begin
          if (cnt_q == 22'd0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 22'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Echo     = echo_q;
  assign bus.busy     = busy_q;
  assign bus.trig_err = trig_err_q;

endmodule
`default_nettype wire
